// File: rtl/cmd_arb_pkg.sv
// Shared types and constants for the command arbiter: opcodes, response codes,
// arbiter state and command-owner encodings.
package cmd_pkg;

  localparam logic [7:0] REQ_BATT  = 8'h01;
  localparam logic [7:0] SET_PTCH  = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] IGNITE    = 8'h07;
  localparam logic [7:0] EMER_LAND = 8'h08;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_NAK = 8'hEE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    RMT  = 2'd1,
    LOC  = 2'd2,
    INT  = 2'd3
  } owner_e;

endpackage

// File: rtl/cmd_arb_sat_cntr.sv
// Saturating up-counter: clr has priority, counts while en, holds at all-ones.
// full is high while the count is all-ones.
module sat_cntr #(
  parameter int W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic full
);

  logic [W-1:0] cnt_reg;

  assign full = &cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && !full) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_arb.sv
// Round-robin arbiter sharing the config command interface between the remote
// and local requesters. Optional link-loss watchdog enabled by CMD_WDOG_EN.
module cmd_arb
  import cmd_pkg::*;
#(
  parameter int RESP_TMO_W = 20,
  parameter int WDOG_W     = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rmt_rdy,
  input  logic [7:0]  rmt_cmd,
  input  logic [15:0] rmt_data,
  output logic        clr_rmt_rdy,
  input  logic        loc_rdy,
  input  logic [7:0]  loc_cmd,
  input  logic [15:0] loc_data,
  output logic        clr_loc_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  rmt_resp,
  output logic        rmt_send_resp,
  output logic [7:0]  loc_resp,
  output logic        loc_send_resp,
  output logic        wdog_trip
);

  arb_state_e  state_reg, state_next;
  owner_e      owner_reg, owner_next;
  owner_e      last_gnt_reg, last_gnt_next;
  logic [7:0]  cmd_reg, cmd_next;
  logic [15:0] data_reg, data_next;
  logic        cmd_rdy_reg, cmd_rdy_next;
  logic        clr_rmt_reg, clr_rmt_next;
  logic        clr_loc_reg, clr_loc_next;
  logic [7:0]  rmt_resp_reg, rmt_resp_next;
  logic [7:0]  loc_resp_reg, loc_resp_next;
  logic        rmt_send_reg, rmt_send_next;
  logic        loc_send_reg, loc_send_next;
  logic        wdog_trip_reg, wdog_trip_next;

  logic        tmo_clr;
  logic        tmo_full;
  logic        wdog_req;
  logic        route;
  logic [7:0]  route_byte;

  // Timer is cleared by the grant itself, so the first busy cycle sees zero;
  // the abort is taken on the edge after it saturates.
  sat_cntr #(.W(RESP_TMO_W)) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tmo_clr),
    .en    (state_reg != IDLE),
    .full  (tmo_full)
  );

`ifdef CMD_WDOG_EN
  logic wdog_full;

  sat_cntr #(.W(WDOG_W)) u_wdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_rmt_reg | wdog_trip_next),
    .en    (1'b1),
    .full  (wdog_full)
  );

  assign wdog_req = wdog_full;
`else
  // Watchdog absent: request is constant zero (WDOG_W is never negative).
  assign wdog_req = (WDOG_W < 0);
`endif

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    last_gnt_next  = last_gnt_reg;
    cmd_next       = cmd_reg;
    data_next      = data_reg;
    cmd_rdy_next   = cmd_rdy_reg;
    clr_rmt_next   = 1'b0;
    clr_loc_next   = 1'b0;
    rmt_resp_next  = rmt_resp_reg;
    loc_resp_next  = loc_resp_reg;
    rmt_send_next  = 1'b0;
    loc_send_next  = 1'b0;
    wdog_trip_next = 1'b0;
    tmo_clr        = 1'b0;
    route          = 1'b0;
    route_byte     = resp;

    case (state_reg)
      IDLE: begin
        if (wdog_req) begin
          cmd_next       = EMER_LAND;
          data_next      = 16'h0000;
          cmd_rdy_next   = 1'b1;
          owner_next     = INT;
          wdog_trip_next = 1'b1;
          tmo_clr        = 1'b1;
          state_next     = ISSUE;
        end else if (rmt_rdy && (!loc_rdy || last_gnt_reg == LOC)) begin
          cmd_next      = rmt_cmd;
          data_next     = rmt_data;
          cmd_rdy_next  = 1'b1;
          clr_rmt_next  = 1'b1;
          owner_next    = RMT;
          last_gnt_next = RMT;
          tmo_clr       = 1'b1;
          state_next    = ISSUE;
        end else if (loc_rdy) begin
          cmd_next      = loc_cmd;
          data_next     = loc_data;
          cmd_rdy_next  = 1'b1;
          clr_loc_next  = 1'b1;
          owner_next    = LOC;
          last_gnt_next = LOC;
          tmo_clr       = 1'b1;
          state_next    = ISSUE;
        end
      end
      ISSUE: begin
        if (clr_cmd_rdy && send_resp) begin
          route = 1'b1;
        end else if (tmo_full) begin
          route      = 1'b1;
          route_byte = RESP_NAK;
        end else if (clr_cmd_rdy) begin
          cmd_rdy_next = 1'b0;
          state_next   = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        if (send_resp) begin
          route = 1'b1;
        end else if (tmo_full) begin
          route      = 1'b1;
          route_byte = RESP_NAK;
        end
      end
      default: state_next = IDLE;
    endcase

    // INT-owned (and ownerless) responses are dropped without a strobe.
    if (route) begin
      cmd_rdy_next = 1'b0;
      owner_next   = NONE;
      state_next   = IDLE;
      if (owner_reg == RMT) begin
        rmt_resp_next = route_byte;
        rmt_send_next = 1'b1;
      end else if (owner_reg == LOC) begin
        loc_resp_next = route_byte;
        loc_send_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      owner_reg     <= NONE;
      last_gnt_reg  <= LOC;
      cmd_reg       <= '0;
      data_reg      <= '0;
      cmd_rdy_reg   <= 1'b0;
      clr_rmt_reg   <= 1'b0;
      clr_loc_reg   <= 1'b0;
      rmt_resp_reg  <= '0;
      loc_resp_reg  <= '0;
      rmt_send_reg  <= 1'b0;
      loc_send_reg  <= 1'b0;
      wdog_trip_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      last_gnt_reg  <= last_gnt_next;
      cmd_reg       <= cmd_next;
      data_reg      <= data_next;
      cmd_rdy_reg   <= cmd_rdy_next;
      clr_rmt_reg   <= clr_rmt_next;
      clr_loc_reg   <= clr_loc_next;
      rmt_resp_reg  <= rmt_resp_next;
      loc_resp_reg  <= loc_resp_next;
      rmt_send_reg  <= rmt_send_next;
      loc_send_reg  <= loc_send_next;
      wdog_trip_reg <= wdog_trip_next;
    end
  end

  assign clr_rmt_rdy   = clr_rmt_reg;
  assign clr_loc_rdy   = clr_loc_reg;
  assign cmd_rdy       = cmd_rdy_reg;
  assign cmd           = cmd_reg;
  assign data          = data_reg;
  assign rmt_resp      = rmt_resp_reg;
  assign rmt_send_resp = rmt_send_reg;
  assign loc_resp      = loc_resp_reg;
  assign loc_send_resp = loc_send_reg;
  assign wdog_trip     = wdog_trip_reg;

endmodule
